// File: rtl/lab_stats_if.sv
// Pixel stream in and per-frame l/a/b statistics out for lab_stats.
// master = upstream pixel source / result consumer, slave = lab_stats.
interface lab_stats_if;
   logic        i_start;
   logic        i_valid;
   logic [15:0] i_l;
   logic [15:0] i_a;
   logic [15:0] i_b;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_mean_l;
   logic [15:0] o_mean_a;
   logic [15:0] o_mean_b;
   logic [15:0] o_var_l;
   logic [15:0] o_var_a;
   logic [15:0] o_var_b;

   modport master (
      output i_start, i_valid, i_l, i_a, i_b,
      input  o_busy, o_done, o_mean_l, o_mean_a, o_mean_b, o_var_l, o_var_a, o_var_b
   );

   modport slave (
      input  i_start, i_valid, i_l, i_a, i_b,
      output o_busy, o_done, o_mean_l, o_mean_a, o_mean_b, o_var_l, o_var_a, o_var_b
   );
endinterface

// File: rtl/lab_stats.sv
// Per-frame mean/variance of l/a/b pixels; o_done 2 cycles after the last pixel's edge.
// No backpressure: always ready in ACCUM; i_valid=0 cycles are plain stalls.
module lab_stats #(
   parameter int NUM_PIX_LOG2 = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   lab_stats_if.slave bus
);
   localparam int N  = NUM_PIX_LOG2;
   localparam int SW = 16 + N;
   localparam int QW = 32 + N;
   localparam int CW = N + 1;
   localparam logic [CW-1:0] LAST_M1 = {1'b0, {N{1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CALC, S_DONE} state_t;

   state_t               state_q;
   logic [CW-1:0]        cnt_q;
   logic                 busy_q;
   logic                 done_q;
   logic signed [SW-1:0] sum_q    [3];
   logic [QW-1:0]        sumsq_q  [3];
   logic [15:0]          mean_q   [3];
   logic [31:0]          meansq_q [3];
   logic [31:0]          ex2_q    [3];
   logic [15:0]          o_mean_q [3];
   logic [15:0]          o_var_q  [3];

   logic [15:0]          pix      [3];
   logic signed [31:0]   px_ext   [3];
   logic [31:0]          sq       [3];
   logic signed [SW-1:0] sum_d    [3];
   logic [QW-1:0]        sumsq_d  [3];
   logic [15:0]          mean_d   [3];
   logic signed [31:0]   mean_ext [3];
   logic [31:0]          meansq_d [3];
   logic [31:0]          ex2_d    [3];
   logic                 borrow   [3];
   logic [19:0]          diff_hi  [3];
   logic [15:0]          var_d    [3];

   always_comb begin
      pix[0] = bus.i_l;
      pix[1] = bus.i_a;
      pix[2] = bus.i_b;
      for (int c = 0; c < 3; c++) begin
         px_ext[c]   = {{16{pix[c][15]}}, pix[c]};
         sq[c]       = px_ext[c] * px_ext[c];
         sum_d[c]    = sum_q[c] + {{N{pix[c][15]}}, pix[c]};
         sumsq_d[c]  = sumsq_q[c] + {{N{1'b0}}, sq[c]};
         // The top 16 bits of the sum are exactly floor(sum / 2^N).
         mean_d[c]   = sum_q[c][N +: 16];
         mean_ext[c] = {{16{mean_d[c][15]}}, mean_d[c]};
         meansq_d[c] = mean_ext[c] * mean_ext[c];
         ex2_d[c]    = sumsq_q[c][N +: 32];
         // diff_hi is bits [32:13] of the 33-bit signed ex2 - meansq.
         borrow[c]   = ex2_q[c][12:0] < meansq_q[c][12:0];
         diff_hi[c]  = {1'b0, ex2_q[c][31:13]} - {1'b0, meansq_q[c][31:13]} - {19'd0, borrow[c]};
         var_d[c]    = diff_hi[c][15:0];
         if (diff_hi[c][19]) begin
            var_d[c] = 16'h0000;
         end else if (|diff_hi[c][18:15]) begin
            var_d[c] = 16'h7FFF;
         end
      end
   end

   // Results and o_done land as DONE hands over to IDLE, so the o_done cycle
   // already accepts the next i_start; busy is held over that cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int c = 0; c < 3; c++) begin
            sum_q[c]    <= '0;
            sumsq_q[c]  <= '0;
            mean_q[c]   <= '0;
            meansq_q[c] <= '0;
            ex2_q[c]    <= '0;
            o_mean_q[c] <= '0;
            o_var_q[c]  <= '0;
         end
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               busy_q <= bus.i_start;
               if (bus.i_start) begin
                  cnt_q   <= '0;
                  state_q <= S_ACCUM;
                  for (int c = 0; c < 3; c++) begin
                     sum_q[c]   <= '0;
                     sumsq_q[c] <= '0;
                  end
               end
            end
            S_ACCUM: begin
               if (bus.i_valid) begin
                  cnt_q <= cnt_q + 1'b1;
                  for (int c = 0; c < 3; c++) begin
                     sum_q[c]   <= sum_d[c];
                     sumsq_q[c] <= sumsq_d[c];
                  end
                  if (cnt_q == LAST_M1) begin
                     state_q <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               for (int c = 0; c < 3; c++) begin
                  mean_q[c]   <= mean_d[c];
                  meansq_q[c] <= meansq_d[c];
                  ex2_q[c]    <= ex2_d[c];
               end
               state_q <= S_DONE;
            end
            S_DONE: begin
               for (int c = 0; c < 3; c++) begin
                  o_mean_q[c] <= mean_q[c];
                  o_var_q[c]  <= var_d[c];
               end
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.o_busy   = busy_q;
   assign bus.o_done   = done_q;
   assign bus.o_mean_l = o_mean_q[0];
   assign bus.o_mean_a = o_mean_q[1];
   assign bus.o_mean_b = o_mean_q[2];
   assign bus.o_var_l  = o_var_q[0];
   assign bus.o_var_a  = o_var_q[1];
   assign bus.o_var_b  = o_var_q[2];
endmodule

// File: tb/tb_lab_stats.sv
// Directed bench for lab_stats with 4-pixel frames (NUM_PIX_LOG2=2).
module tb_lab_stats;
   logic i_clk = 1'b0;
   logic i_rst;
   int   checks   = 0;
   int   failures = 0;
   int   busy_lo  = 0;
   int   done_cnt = 0;
   bit   mon      = 1'b0;
   logic [15:0] pl [4];
   logic [15:0] pa [4];
   logic [15:0] pb [4];

   lab_stats_if bus ();

   lab_stats #(.NUM_PIX_LOG2(2)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus.slave)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
      if (mon) begin
         if (!bus.o_busy) busy_lo++;
         if (bus.o_done) done_cnt++;
      end
   endtask

   // n pixels from pl/pa/pb, each preceded by gap stall cycles carrying junk data
   task automatic feed(input int n, input int gap, input bit poke_start);
      for (int i = 0; i < n; i++) begin
         for (int g = 0; g < gap; g++) begin
            bus.i_valid = 1'b0;
            bus.i_start = poke_start;
            bus.i_l = 16'h7FFF; bus.i_a = 16'h7FFF; bus.i_b = 16'h7FFF;
            step();
         end
         bus.i_start = 1'b0;
         bus.i_l = pl[i]; bus.i_a = pa[i]; bus.i_b = pb[i];
         bus.i_valid = 1'b1;
         step();
      end
      bus.i_valid = 1'b0;
      bus.i_start = 1'b0;
   endtask

   task automatic start_frame();
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (bus.o_done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      step();
      step();
      checks++;
      if ({bus.o_busy, bus.o_done} !== 2'b00) begin
         failures++; $display("FAIL reset_flags: got %b expected 00", {bus.o_busy, bus.o_done});
      end
      checks++;
      if ({bus.o_mean_l, bus.o_mean_a, bus.o_mean_b} !== 48'h0) begin
         failures++; $display("FAIL reset_mean: got %h expected 0", {bus.o_mean_l, bus.o_mean_a, bus.o_mean_b});
      end
      checks++;
      if ({bus.o_var_l, bus.o_var_a, bus.o_var_b} !== 48'h0) begin
         failures++; $display("FAIL reset_var: got %h expected 0", {bus.o_var_l, bus.o_var_a, bus.o_var_b});
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      step();
      checks++;
      if (bus.o_busy !== 1'b0) begin
         failures++; $display("FAIL reset_idle_busy: got %b expected 0", bus.o_busy);
      end
   endtask

   task automatic test_constant();
      int lat;
      pl = '{default: 16'h2000}; pa = '{default: 16'h2000}; pb = '{default: 16'h2000};
      start_frame();
      feed(4, 0, 1'b0);
      wait_done(lat);
      checks++;
      if (lat !== 2) begin
         failures++; $display("FAIL const_latency: got %0d expected 2", lat);
      end
      checks++;
      if (bus.o_busy !== 1'b1) begin
         failures++; $display("FAIL const_busy_in_done: got %b expected 1", bus.o_busy);
      end
      checks++;
      if ({bus.o_mean_l, bus.o_mean_a, bus.o_mean_b} !== 48'h2000_2000_2000) begin
         failures++; $display("FAIL const_mean: got %h expected 200020002000", {bus.o_mean_l, bus.o_mean_a, bus.o_mean_b});
      end
      checks++;
      if ({bus.o_var_l, bus.o_var_a, bus.o_var_b} !== 48'h0) begin
         failures++; $display("FAIL const_var: got %h expected 0", {bus.o_var_l, bus.o_var_a, bus.o_var_b});
      end
      step();
      checks++;
      if ({bus.o_busy, bus.o_done} !== 2'b00) begin
         failures++; $display("FAIL const_after_done: got %b expected 00", {bus.o_busy, bus.o_done});
      end
   endtask

   task automatic test_variance();
      int lat;
      pl = '{16'h2000, 16'h2000, 16'hE000, 16'hE000};
      pa = '{default: 16'h0000}; pb = '{default: 16'h0000};
      start_frame();
      feed(4, 0, 1'b0);
      wait_done(lat);
      checks++;
      if (lat !== 2) begin
         failures++; $display("FAIL var_latency: got %0d expected 2", lat);
      end
      checks++;
      if ({bus.o_mean_l, bus.o_mean_a, bus.o_mean_b} !== 48'h0) begin
         failures++; $display("FAIL var_mean: got %h expected 0", {bus.o_mean_l, bus.o_mean_a, bus.o_mean_b});
      end
      checks++;
      if ({bus.o_var_l, bus.o_var_a, bus.o_var_b} !== 48'h2000_0000_0000) begin
         failures++; $display("FAIL var_var: got %h expected 200000000000", {bus.o_var_l, bus.o_var_a, bus.o_var_b});
      end
   endtask

   // l saturates, a has a non-zero mean with variance 0.25, b has a floored
   // negative mean whose ex2 - meansq goes negative and clamps to 0
   task automatic set_mixed();
      pl = '{16'h6000, 16'hA000, 16'h6000, 16'hA000};
      pa = '{16'h1000, 16'h3000, 16'h1000, 16'h3000};
      pb = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE};
   endtask

   task automatic test_saturate_mixed();
      int lat;
      set_mixed();
      start_frame();
      feed(4, 0, 1'b0);
      wait_done(lat);
      checks++;
      if (lat !== 2) begin
         failures++; $display("FAIL mixed_latency: got %0d expected 2", lat);
      end
      checks++;
      if ({bus.o_mean_l, bus.o_mean_a, bus.o_mean_b} !== 48'h0000_2000_FFFE) begin
         failures++; $display("FAIL mixed_mean: got %h expected 00002000fffe", {bus.o_mean_l, bus.o_mean_a, bus.o_mean_b});
      end
      checks++;
      if ({bus.o_var_l, bus.o_var_a, bus.o_var_b} !== 48'h7FFF_0800_0000) begin
         failures++; $display("FAIL mixed_var: got %h expected 7fff08000000", {bus.o_var_l, bus.o_var_a, bus.o_var_b});
      end
   endtask

   task automatic test_start_with_valid();
      int lat;
      pl = '{default: 16'h2000}; pa = '{default: 16'h2000}; pb = '{default: 16'h2000};
      bus.i_l = 16'h7FFF; bus.i_a = 16'h7FFF; bus.i_b = 16'h7FFF;
      bus.i_start = 1'b1;
      bus.i_valid = 1'b1;
      step();
      bus.i_start = 1'b0;
      bus.i_valid = 1'b0;
      feed(4, 0, 1'b0);
      wait_done(lat);
      checks++;
      if (lat !== 2) begin
         failures++; $display("FAIL sv_latency: got %0d expected 2", lat);
      end
      checks++;
      if ({bus.o_mean_l, bus.o_mean_a, bus.o_mean_b} !== 48'h2000_2000_2000) begin
         failures++; $display("FAIL sv_mean: got %h expected 200020002000", {bus.o_mean_l, bus.o_mean_a, bus.o_mean_b});
      end
      checks++;
      if ({bus.o_var_l, bus.o_var_a, bus.o_var_b} !== 48'h0) begin
         failures++; $display("FAIL sv_var: got %h expected 0", {bus.o_var_l, bus.o_var_a, bus.o_var_b});
      end
   endtask

   task automatic test_stall();
      int lat;
      int extra;
      pl = '{16'h2000, 16'h2000, 16'hE000, 16'hE000};
      pa = '{default: 16'h0000}; pb = '{default: 16'h0000};
      start_frame();
      busy_lo = 0; done_cnt = 0; mon = 1'b1;
      feed(4, 2, 1'b1);
      wait_done(lat);
      mon = 1'b0;
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.o_done) extra++;
      end
      checks++;
      if (lat !== 2) begin
         failures++; $display("FAIL stall_latency: got %0d expected 2", lat);
      end
      checks++;
      if (busy_lo !== 0) begin
         failures++; $display("FAIL stall_busy_low_cycles: got %0d expected 0", busy_lo);
      end
      checks++;
      if (done_cnt + extra !== 1) begin
         failures++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt + extra);
      end
      checks++;
      if ({bus.o_mean_l, bus.o_mean_a, bus.o_mean_b} !== 48'h0) begin
         failures++; $display("FAIL stall_mean: got %h expected 0", {bus.o_mean_l, bus.o_mean_a, bus.o_mean_b});
      end
      checks++;
      if ({bus.o_var_l, bus.o_var_a, bus.o_var_b} !== 48'h2000_0000_0000) begin
         failures++; $display("FAIL stall_var: got %h expected 200000000000", {bus.o_var_l, bus.o_var_a, bus.o_var_b});
      end
   endtask

   task automatic test_reset_mid_frame();
      int lat;
      int dones;
      pl = '{default: 16'h4000}; pa = '{default: 16'h4000}; pb = '{default: 16'h4000};
      start_frame();
      feed(2, 0, 1'b0);
      #3;
      i_rst = 1'b1;
      #1;
      checks++;
      if ({bus.o_busy, bus.o_done} !== 2'b00) begin
         failures++; $display("FAIL midrst_flags: got %b expected 00", {bus.o_busy, bus.o_done});
      end
      checks++;
      if ({bus.o_var_l, bus.o_var_a, bus.o_var_b, bus.o_mean_l, bus.o_mean_a, bus.o_mean_b} !== 96'h0) begin
         failures++; $display("FAIL midrst_outputs: got %h expected 0",
            {bus.o_var_l, bus.o_var_a, bus.o_var_b, bus.o_mean_l, bus.o_mean_a, bus.o_mean_b});
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.o_done) dones++;
      end
      checks++;
      if (dones !== 0) begin
         failures++; $display("FAIL midrst_no_done: got %0d expected 0", dones);
      end
      set_mixed();
      start_frame();
      feed(4, 0, 1'b0);
      wait_done(lat);
      checks++;
      if (lat !== 2) begin
         failures++; $display("FAIL midrst_latency: got %0d expected 2", lat);
      end
      checks++;
      if ({bus.o_mean_l, bus.o_mean_a, bus.o_mean_b, bus.o_var_l, bus.o_var_a, bus.o_var_b}
          !== 96'h0000_2000_FFFE_7FFF_0800_0000) begin
         failures++; $display("FAIL midrst_results: got %h expected 00002000fffe7fff08000000",
            {bus.o_mean_l, bus.o_mean_a, bus.o_mean_b, bus.o_var_l, bus.o_var_a, bus.o_var_b});
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      pl = '{default: 16'h2000}; pa = '{default: 16'h2000}; pb = '{default: 16'h2000};
      start_frame();
      feed(4, 0, 1'b0);
      wait_done(lat);
      checks++;
      if (lat !== 2) begin
         failures++; $display("FAIL b2b_first_latency: got %0d expected 2", lat);
      end
      // restart from the o_done cycle, i.e. at edge k+3
      set_mixed();
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
      checks++;
      if ({bus.o_busy, bus.o_done} !== 2'b10) begin
         failures++; $display("FAIL b2b_restart_flags: got %b expected 10", {bus.o_busy, bus.o_done});
      end
      feed(4, 0, 1'b0);
      checks++;
      if ({bus.o_mean_l, bus.o_mean_a, bus.o_mean_b, bus.o_var_l, bus.o_var_a, bus.o_var_b}
          !== 96'h2000_2000_2000_0000_0000_0000) begin
         failures++; $display("FAIL b2b_held: got %h expected 200020002000000000000000",
            {bus.o_mean_l, bus.o_mean_a, bus.o_mean_b, bus.o_var_l, bus.o_var_a, bus.o_var_b});
      end
      wait_done(lat);
      checks++;
      if (lat !== 2) begin
         failures++; $display("FAIL b2b_second_latency: got %0d expected 2", lat);
      end
      checks++;
      if ({bus.o_mean_l, bus.o_mean_a, bus.o_mean_b, bus.o_var_l, bus.o_var_a, bus.o_var_b}
          !== 96'h0000_2000_FFFE_7FFF_0800_0000) begin
         failures++; $display("FAIL b2b_second_results: got %h expected 00002000fffe7fff08000000",
            {bus.o_mean_l, bus.o_mean_a, bus.o_mean_b, bus.o_var_l, bus.o_var_a, bus.o_var_b});
      end
   endtask

   initial begin
      i_rst       = 1'b1;
      bus.i_start = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_l     = 16'h0000;
      bus.i_a     = 16'h0000;
      bus.i_b     = 16'h0000;
      test_reset();
      test_constant();
      test_variance();
      test_saturate_mixed();
      test_start_with_valid();
      test_stall();
      test_reset_mid_frame();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
